// File: rtl/cook_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cook_sequencer_if
// Description : Program-load, control and status signals of the multi-stage
//               cooking sequencer. The master side is the keypad/loader and
//               display logic; the slave side is the sequencer core.
// Revision    : 1.0 - initial release
// ============================================================================
interface cook_sequencer_if #(
    parameter int STAGES = 4,
    parameter int DIGITS = 4,
    parameter int LVL_W  = 2
);
    localparam int c_IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int c_CNT_W = $clog2(STAGES + 1);

    // Program loading and control
    logic                   prog_we;
    logic [c_IDX_W-1:0]     prog_idx;
    logic [4*DIGITS-1:0]    prog_dur;
    logic [LVL_W-1:0]       prog_lvl;
    logic [c_CNT_W-1:0]     prog_count;
    logic                   start;
    logic                   stop;
    logic                   door_open;

    // Status towards display and power stage
    logic [2:0]             state;
    logic [c_IDX_W-1:0]     stage_idx;
    logic [4*DIGITS-1:0]    remaining;
    logic                   pwm_out;
    logic                   motor_on;
    logic                   busy;
    logic                   done;

    modport master (
        output prog_we, prog_idx, prog_dur, prog_lvl, prog_count,
        output start, stop, door_open,
        input  state, stage_idx, remaining, pwm_out, motor_on, busy, done
    );

    modport slave (
        input  prog_we, prog_idx, prog_dur, prog_lvl, prog_count,
        input  start, stop, door_open,
        output state, stage_idx, remaining, pwm_out, motor_on, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/cook_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cook_sequencer
// Description : Multi-stage cooking controller. Holds STAGES program slots
//               (BCD duration + heat level), runs them in order with a 1 s
//               BCD countdown, drives magnetron PWM and turntable motor.
//               Optional door interlock: define COOK_DOOR_INTERLOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cook_sequencer #(
    parameter int STAGES   = 4,
    parameter int DIGITS   = 4,
    parameter int LVL_W    = 2,
    parameter int TICK_DIV = 50_000_000,
    parameter int PWM_DIV  = 5_000_000
) (
    input  logic               clock,
    input  logic               reset,
    cook_sequencer_if.slave    bus
);

    localparam int c_IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int c_CNT_W  = $clog2(STAGES + 1);
    localparam int c_DUR_W  = 4 * DIGITS;
    localparam int c_LMAX   = (1 << LVL_W) - 1;
    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_PDIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Program storage
    logic [c_DUR_W-1:0]  r_slot_dur [STAGES];
    logic [LVL_W-1:0]    r_slot_lvl [STAGES];

    // Sequencer state and registered outputs
    state_t              r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_DUR_W-1:0]  r_rem;
    logic [c_CNT_W-1:0]  r_count;
    logic [LVL_W-1:0]    r_lvl;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_PDIV_W-1:0] r_pdiv;
    logic [LVL_W-1:0]    r_p;
    logic                r_pwm;
    logic                r_motor;
    logic                r_busy;
    logic                r_done;

    // Next-state values
    state_t              w_state_nxt;
    logic [c_IDX_W-1:0]  w_idx_nxt;
    logic [c_DUR_W-1:0]  w_rem_nxt;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [LVL_W-1:0]    w_lvl_nxt;
    logic [c_TICK_W-1:0] w_tick_nxt;
    logic [c_PDIV_W-1:0] w_pdiv_nxt;
    logic [LVL_W-1:0]    w_p_nxt;

    logic                w_door;
    logic                w_start_ok;
    logic [c_CNT_W-1:0]  w_n;
    logic                w_last;
    logic                w_idx_ok;
    logic [c_DUR_W-1:0]  w_rem_dec;

`ifdef COOK_DOOR_INTERLOCK_EN
    assign w_door = bus.door_open;
`else
    // Door input has no effect in this build.
    logic w_unused_door;
    assign w_unused_door = bus.door_open;
    assign w_door        = 1'b0;
`endif

    // Clamp every BCD digit to 9 so stored durations are always valid decimal.
    function automatic logic [c_DUR_W-1:0] bcd_sat(input logic [c_DUR_W-1:0] v);
        logic [c_DUR_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Pure decimal decrement: a zero digit borrows and becomes 9.
    function automatic logic [c_DUR_W-1:0] bcd_dec(input logic [c_DUR_W-1:0] v);
        logic [c_DUR_W-1:0] r;
        logic               borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Stop dominates start; with the interlock an open door also blocks start.
    assign w_start_ok = bus.start && !bus.stop && !w_door;
    assign w_n        = (bus.prog_count > c_CNT_W'(STAGES)) ? c_CNT_W'(STAGES) : bus.prog_count;
    assign w_last     = ((c_CNT_W'(r_idx) + c_CNT_W'(1)) == r_count);
    assign w_idx_ok   = ({1'b0, bus.prog_idx} < (c_IDX_W + 1)'(STAGES));
    assign w_rem_dec  = bcd_dec(r_rem);

    // Program slot writes, accepted only while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_slot_dur[i] <= '0;
                r_slot_lvl[i] <= '0;
            end
        end else if (r_state == ST_IDLE && bus.prog_we && w_idx_ok) begin
            r_slot_dur[bus.prog_idx] <= bcd_sat(bus.prog_dur);
            r_slot_lvl[bus.prog_idx] <= bus.prog_lvl;
        end
    end

    // Next-state and datapath decisions for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rem_nxt   = r_rem;
        w_count_nxt = r_count;
        w_lvl_nxt   = r_lvl;
        w_tick_nxt  = r_tick;
        w_pdiv_nxt  = r_pdiv;
        w_p_nxt     = r_p;

        case (r_state)
            ST_IDLE: begin
                if (w_start_ok && (w_n != '0)) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_nxt   = '0;
                    w_count_nxt = w_n;
                end
            end

            ST_LOAD: begin
                w_rem_nxt  = r_slot_dur[r_idx];
                w_lvl_nxt  = r_slot_lvl[r_idx];
                w_tick_nxt = '0;
                w_pdiv_nxt = '0;
                w_p_nxt    = '0;
                if (r_slot_dur[r_idx] == '0) begin
                    // Zero-length stage: skip it without entering RUN.
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + c_IDX_W'(1);
                        w_state_nxt = ST_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.stop || w_door) begin
                    // Counters freeze so a resume continues mid-second.
                    w_state_nxt = ST_PAUSE;
                end else begin
                    if (r_pdiv == c_PDIV_W'(PWM_DIV - 1)) begin
                        w_pdiv_nxt = '0;
                        w_p_nxt    = (r_p == LVL_W'(c_LMAX - 1)) ? '0 : r_p + LVL_W'(1);
                    end else begin
                        w_pdiv_nxt = r_pdiv + c_PDIV_W'(1);
                    end

                    if (r_tick == c_TICK_W'(TICK_DIV - 1)) begin
                        w_tick_nxt = '0;
                        w_rem_nxt  = w_rem_dec;
                        if (w_rem_dec == '0) begin
                            if (w_last) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_idx_nxt   = r_idx + c_IDX_W'(1);
                                w_state_nxt = ST_LOAD;
                            end
                        end
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_W'(1);
                    end
                end
            end

            ST_PAUSE: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_tick_nxt  = '0;
                    w_pdiv_nxt  = '0;
                    w_p_nxt     = '0;
                end else if (w_start_ok) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_DONE: begin
                if (bus.stop || bus.start) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with all outputs registered from the next-state values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_rem   <= '0;
            r_count <= '0;
            r_lvl   <= '0;
            r_tick  <= '0;
            r_pdiv  <= '0;
            r_p     <= '0;
            r_pwm   <= 1'b0;
            r_motor <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_rem   <= w_rem_nxt;
            r_count <= w_count_nxt;
            r_lvl   <= w_lvl_nxt;
            r_tick  <= w_tick_nxt;
            r_pdiv  <= w_pdiv_nxt;
            r_p     <= w_p_nxt;
            r_pwm   <= (w_state_nxt == ST_RUN) && (w_p_nxt < w_lvl_nxt) && !w_door;
            r_motor <= (w_state_nxt == ST_RUN);
            r_busy  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RUN) ||
                       (w_state_nxt == ST_PAUSE);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.state     = r_state;
    assign bus.stage_idx = r_idx;
    assign bus.remaining = r_rem;
    assign bus.pwm_out   = r_pwm;
    assign bus.motor_on  = r_motor;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cook_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cook_sequencer
// Description : Directed self-checking bench for cook_sequencer with
//               TICK_DIV=4, PWM_DIV=1, DIGITS=2, STAGES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cook_sequencer;

    localparam int STAGES   = 4;
    localparam int DIGITS   = 2;
    localparam int LVL_W    = 2;
    localparam int TICK_DIV = 4;
    localparam int PWM_DIV  = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    cook_sequencer_if #(.STAGES(STAGES), .DIGITS(DIGITS), .LVL_W(LVL_W)) bus ();

    cook_sequencer #(
        .STAGES  (STAGES),
        .DIGITS  (DIGITS),
        .LVL_W   (LVL_W),
        .TICK_DIV(TICK_DIV),
        .PWM_DIV (PWM_DIV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    logic [2:0] s_state [64];
    logic [7:0] s_rem   [64];
    logic [1:0] s_idx   [64];
    logic       s_pwm   [64];
    logic       s_done  [64];
    int         highs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_slot(input int idx, input logic [7:0] dur, input logic [1:0] lvl);
        bus.prog_we  = 1'b1;
        bus.prog_idx = 2'(idx);
        bus.prog_dur = dur;
        bus.prog_lvl = lvl;
        step();
        bus.prog_we  = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    // Capture n consecutive cycles of outputs, the first being the current one.
    task automatic record(input int n);
        for (int k = 0; k < n; k++) begin
            s_state[k] = bus.state;
            s_rem[k]   = bus.remaining;
            s_idx[k]   = bus.stage_idx;
            s_pwm[k]   = bus.pwm_out;
            s_done[k]  = bus.done;
            step();
        end
    endtask

    initial begin
        bus.prog_we    = 1'b0;
        bus.prog_idx   = '0;
        bus.prog_dur   = '0;
        bus.prog_lvl   = '0;
        bus.prog_count = '0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.door_open  = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset values
        check("rst_state", bus.state, 0);
        check("rst_rem", bus.remaining, 0);
        check("rst_idx", bus.stage_idx, 0);
        check("rst_flags", {bus.pwm_out, bus.motor_on, bus.busy, bus.done}, 0);

        // Two stages: 3 s at level 3, then 2 s at level 1
        write_slot(0, 8'h03, 2'd3);
        write_slot(1, 8'h02, 2'd1);
        bus.prog_count = 2;
        pulse_start();
        check("s1_load", bus.state, 1);
        check("s1_load_busy", bus.busy, 1);
        step();
        check("s1_run", bus.state, 2);
        check("s1_motor", bus.motor_on, 1);
        record(22);
        check("s1_rem0", s_rem[0], 8'h03);
        check("s1_rem4", s_rem[4], 8'h02);
        check("s1_rem8", s_rem[8], 8'h01);
        check("s1_gap_load", s_state[12], 1);
        check("s1_gap_idx", s_idx[12], 1);
        check("s1_rem13", s_rem[13], 8'h02);
        check("s1_last_run", s_state[20], 2);
        check("s1_done_early", s_done[20], 0);
        check("s1_done_state", s_state[21], 4);
        check("s1_done", s_done[21], 1);
        highs = 0;
        for (int k = 0; k < 12; k++) highs += int'(s_pwm[k]);
        check("s1_pwm_stage0", highs, 12);
        highs = 0;
        for (int k = 13; k < 21; k++) highs += int'(s_pwm[k]);
        check("s1_pwm_stage1", highs, 3);
        check("s1_pwm_pat", {s_pwm[13], s_pwm[14], s_pwm[15], s_pwm[16]}, 4'b1001);
        check("s1_done_hold", bus.done, 1);
        pulse_stop();
        check("s1_stop_idle", bus.state, 0);
        check("s1_stop_done", bus.done, 0);

        // Decimal borrow and zero-length stage skip
        write_slot(0, 8'h10, 2'd2);
        write_slot(1, 8'h00, 2'd2);
        write_slot(2, 8'h01, 2'd2);
        bus.prog_count = 3;
        pulse_start();
        step();
        record(47);
        check("s2_rem3", s_rem[3], 8'h10);
        check("s2_rem4", s_rem[4], 8'h09);
        check("s2_load1", {s_state[40], 1'b0, s_idx[40]}, {3'd1, 1'b0, 2'd1});
        check("s2_load2", {s_state[41], 1'b0, s_idx[41]}, {3'd1, 1'b0, 2'd2});
        check("s2_run2", {s_state[42], 1'b0, s_idx[42]}, {3'd2, 1'b0, 2'd2});
        check("s2_rem42", s_rem[42], 8'h01);
        check("s2_done", s_state[46], 4);
        pulse_start();
        check("s2_start_in_done", bus.state, 0);
        step();
        check("s2_no_restart", bus.state, 0);

        // Pause and resume with remaining frozen
        write_slot(0, 8'h05, 2'd2);
        bus.prog_count = 1;
        pulse_start();
        step();
        check("s3_rem", bus.remaining, 8'h05);
        pulse_stop();
        check("s3_pause", bus.state, 3);
        check("s3_pause_rem", bus.remaining, 8'h05);
        check("s3_pause_pwm", bus.pwm_out, 0);
        check("s3_pause_motor", bus.motor_on, 0);
        check("s3_pause_busy", bus.busy, 1);
        step();
        step();
        check("s3_frozen", bus.remaining, 8'h05);
        pulse_start();
        check("s3_resume", bus.state, 2);
        check("s3_resume_pwm", bus.pwm_out, 1);
        step();
        step();
        step();
        check("s3_rem_hold", bus.remaining, 8'h05);
        step();
        check("s3_rem_dec", bus.remaining, 8'h04);
        pulse_stop();
        pulse_stop();
        check("s3_idle", bus.state, 0);
        check("s3_idle_rem", bus.remaining, 8'h00);
        check("s3_idle_idx", bus.stage_idx, 0);
        check("s3_idle_busy", bus.busy, 0);

        // Simultaneous start and stop in PAUSE
        pulse_start();
        step();
        pulse_stop();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("s4_both_idle", bus.state, 0);

        // Zero count start is ignored
        bus.prog_count = 0;
        pulse_start();
        check("s4_cnt0", bus.state, 0);
        step();
        check("s4_cnt0_hold", bus.state, 0);

        // Writes during RUN are ignored
        bus.prog_count = 1;
        pulse_start();
        step();
        write_slot(0, 8'h02, 2'd1);
        pulse_stop();
        pulse_stop();
        pulse_start();
        step();
        check("s4_we_ignored", bus.remaining, 8'h05);
        pulse_stop();
        pulse_stop();

        // Digit saturation and level 0
        write_slot(0, 8'hAF, 2'd0);
        pulse_start();
        step();
        check("s5_sat", bus.remaining, 8'h99);
        check("s5_lvl0_pwm", bus.pwm_out, 0);
        step();
        step();
        check("s5_lvl0_pwm2", bus.pwm_out, 0);
        pulse_stop();
        pulse_stop();

        // Door handling
        write_slot(0, 8'h05, 2'd3);
        pulse_start();
        step();
        check("s6_run_pwm", bus.pwm_out, 1);
        bus.door_open = 1'b1;
        step();
`ifdef COOK_DOOR_INTERLOCK_EN
        check("s6_door_pause", bus.state, 3);
        check("s6_door_pwm", bus.pwm_out, 0);
        pulse_start();
        check("s6_door_start", bus.state, 3);
        bus.door_open = 1'b0;
        pulse_start();
        check("s6_door_resume", bus.state, 2);
        pulse_stop();
`else
        check("s6_door_ignored", bus.state, 2);
        check("s6_door_pwm", bus.pwm_out, 1);
        bus.door_open = 1'b0;
        pulse_stop();
`endif
        pulse_stop();
        check("s6_idle", bus.state, 0);

        // Reset mid-run in stage 1, then slots must read back empty
        write_slot(0, 8'h01, 2'd1);
        write_slot(1, 8'h02, 2'd1);
        bus.prog_count = 2;
        pulse_start();
        step();
        for (int k = 0; k < 5; k++) step();
        check("s7_run_idx1", {bus.state, 1'b0, bus.stage_idx}, {3'd2, 1'b0, 2'd1});
        reset = 1'b1;
        step();
        check("s7_rst_state", bus.state, 0);
        check("s7_rst_idx", bus.stage_idx, 0);
        check("s7_rst_rem", bus.remaining, 0);
        check("s7_rst_flags", {bus.pwm_out, bus.motor_on, bus.busy, bus.done}, 0);
        reset = 1'b0;
        bus.prog_count = 7;
        pulse_start();
        check("s7_skip0", {bus.state, 1'b0, bus.stage_idx}, {3'd1, 1'b0, 2'd0});
        step();
        check("s7_skip1", {bus.state, 1'b0, bus.stage_idx}, {3'd1, 1'b0, 2'd1});
        step();
        check("s7_skip2", {bus.state, 1'b0, bus.stage_idx}, {3'd1, 1'b0, 2'd2});
        step();
        check("s7_skip3", {bus.state, 1'b0, bus.stage_idx}, {3'd1, 1'b0, 2'd3});
        step();
        check("s7_empty_done", bus.state, 4);
        check("s7_empty_done_flag", bus.done, 1);
        pulse_stop();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
